mem_arbiter: RTL and testbench

- Shares the single-port data/instruction memory bank between the instruction-fetch port (read-only) and the data-access port (read/write).
- Arbitrates between the two ports with round-robin priority and issues one access at a time to the memory.
- Waits a fixed, parameterised read latency, then returns a registered one-cycle completion pulse with read data to the winning requester.
- Sits between the fetch/memory stages and the memory wrapper; the stall logic uses `*_done`.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_arb_pkg
// Brief   : Shared state encoding, port IDs and limits for the memory arbiter.
// Rev     : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PORT_IF     = 1'b0;
    localparam logic PORT_D      = 1'b1;
    localparam int   MAX_LATENCY = 4;
    localparam int   CNT_W       = 3;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-requester round-robin picker (combinational).
// Rev     : 1.0
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = PORT_IF;
        if (req_i[PORT_IF] && req_i[PORT_D]) begin
            grant_o = ~last_grant_i;
        end else if (req_i[PORT_D]) begin
            grant_o = PORT_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares one memory bank between fetch and data ports, one access
//           at a time, with a fixed read latency and a done pulse per access.
// Rev     : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    localparam int C_LAT_CLAMP = (LATENCY < 1) ? 1 :
                                 (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(C_LAT_CLAMP);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [15:0]      own_addr_q, own_addr_d;
    logic [15:0]      own_wdata_q, own_wdata_d;
    logic             own_wr_q, own_wr_d;
    logic [15:0]      if_rdata_q, if_rdata_d;
    logic [15:0]      d_rdata_q, d_rdata_d;
    logic             if_done_q, if_done_d;
    logic             d_done_q, d_done_d;
    logic             err_q, err_d;

    logic             w_grant;
    logic             w_viol;

    rr_arb2 u_rr_arb2 (
        .req_i        ({d_req, if_req}),
        .last_grant_i (last_grant_q),
        .grant_o      (w_grant)
    );

    // Owner must hold req and keep its request fields stable while waiting.
    always_comb begin
        w_viol = 1'b0;
        if (owner_q == PORT_IF) begin
            w_viol = !if_req || (if_addr != own_addr_q);
        end else begin
            w_viol = !d_req || (d_addr != own_addr_q) ||
                     (d_wr != own_wr_q) || (d_wdata != own_wdata_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        own_addr_d   = own_addr_q;
        own_wdata_d  = own_wdata_q;
        own_wr_d     = own_wr_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        err_d        = err_q;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    if (w_grant == PORT_D) begin
                        mem_write_en = d_wr;
                        mem_read_en  = !d_wr;
                        mem_addr     = d_addr;
                        mem_wdata    = d_wdata;
                        own_addr_d   = d_addr;
                        own_wr_d     = d_wr;
                        own_wdata_d  = d_wdata;
                    end else begin
                        mem_read_en  = 1'b1;
                        mem_addr     = if_addr;
                        own_addr_d   = if_addr;
                        own_wr_d     = 1'b0;
                        own_wdata_d  = 16'h0000;
                    end
                    owner_d      = w_grant;
                    last_grant_d = w_grant;
                    cnt_d        = C_CNT_LOAD;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                err_d = err_q | w_viol;
                // Capture on the last wait cycle; done is registered into RESP.
                if (cnt_q <= CNT_W'(1)) begin
                    if (owner_q == PORT_IF) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end else begin
                        d_rdata_d  = own_wr_q ? 16'h0000 : mem_rdata;
                        d_done_d   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= PORT_IF;
            last_grant_q <= PORT_IF;
            own_addr_q   <= 16'h0000;
            own_wdata_q  <= 16'h0000;
            own_wr_q     <= 1'b0;
            if_rdata_q   <= 16'h0000;
            d_rdata_q    <= 16'h0000;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            own_addr_q   <= own_addr_d;
            own_wdata_q  <= own_wdata_d;
            own_wr_q     <= own_wr_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
        end
    end

    assign if_done  = if_done_q;
    assign if_rdata = if_rdata_q;
    assign d_done   = d_done_q;
    assign d_rdata  = d_rdata_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Runs one arbiter per LATENCY value 1..4 against a timeline model.
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int N = 4;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a     [N];
    logic        if_req_a  [N];
    logic [15:0] if_addr_a [N];
    logic        d_req_a   [N];
    logic        d_wr_a    [N];
    logic [15:0] d_addr_a  [N];
    logic [15:0] d_wdata_a [N];

    wire  [N-1:0] if_done_w;
    wire  [N-1:0] d_done_w;
    wire  [N-1:0] mem_re_w;
    wire  [N-1:0] mem_we_w;
    wire  [N-1:0] err_w;
    wire  [15:0]  if_rdata_w  [N];
    wire  [15:0]  d_rdata_w   [N];
    wire  [15:0]  mem_addr_w  [N];
    wire  [15:0]  mem_wdata_w [N];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_k    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s LAT=%0d t=%0t: got 0x%0h expected 0x%0h", tag, cur_k + 1, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // One DUT per latency, each with its own latency-accurate memory.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = g + 1;
        logic [15:0] rmem   [1024];
        logic [15:0] pipe_d [L+1];
        logic        pipe_v [L+1];
        logic [15:0] noise;
        wire  [15:0] rdata_g = pipe_v[L] ? pipe_d[L] : noise;

        initial begin
            for (int i = 0; i < 1024; i++) rmem[i] = init_word(16'(i));
            for (int i = 0; i <= L; i++) begin
                pipe_v[i] = 1'b0;
                pipe_d[i] = 16'h0000;
            end
            noise = 16'h0000;
            forever begin
                @(posedge clk);
                if (mem_we_w[g]) rmem[mem_addr_w[g][9:0]] <= mem_wdata_w[g];
                pipe_v[1] <= mem_re_w[g];
                pipe_d[1] <= rmem[mem_addr_w[g][9:0]];
                for (int i = 2; i <= L; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                    pipe_d[i] <= pipe_d[i-1];
                end
                noise <= 16'($urandom);
            end
        end

        mem_arbiter #(.LATENCY(L)) u_dut (
            .clk          (clk),
            .rst          (rst_a[g]),
            .if_req       (if_req_a[g]),
            .if_addr      (if_addr_a[g]),
            .if_done      (if_done_w[g]),
            .if_rdata     (if_rdata_w[g]),
            .d_req        (d_req_a[g]),
            .d_wr         (d_wr_a[g]),
            .d_addr       (d_addr_a[g]),
            .d_wdata      (d_wdata_a[g]),
            .d_done       (d_done_w[g]),
            .d_rdata      (d_rdata_w[g]),
            .mem_read_en  (mem_re_w[g]),
            .mem_write_en (mem_we_w[g]),
            .mem_addr     (mem_addr_w[g]),
            .mem_wdata    (mem_wdata_w[g]),
            .mem_rdata    (rdata_g),
            .err          (err_w[g])
        );
    end

    // Reference model: each access occupies the bank for LATENCY+2 cycles,
    // completes at issue+LATENCY+1, and ties go to the port not served last.
    logic [15:0] shadow      [N][1024];
    logic        m_busy      [N];
    int          m_free      [N];
    int          m_issue     [N];
    int          m_done_cyc  [N];
    logic        m_last_d    [N];
    logic        m_own_d     [N];
    logic        m_own_wr    [N];
    logic [15:0] m_own_addr  [N];
    logic [15:0] m_own_wdata [N];
    logic [15:0] m_data      [N];
    logic [15:0] m_if_hold   [N];
    logic [15:0] m_d_hold    [N];
    logic        m_err       [N];
    int          cyc = 0;

    initial begin : p_model
        logic        win_d, viol;
        logic        e_re, e_we, e_ifd, e_dd;
        logic [15:0] e_addr, e_wd;
        int          lat;
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 1024; a++) shadow[k][a] = init_word(16'(a));
            m_busy[k] = 1'b0; m_free[k] = 0; m_issue[k] = 0; m_done_cyc[k] = 0;
            m_last_d[k] = 1'b0; m_own_d[k] = 1'b0; m_own_wr[k] = 1'b0;
            m_own_addr[k] = 16'h0; m_own_wdata[k] = 16'h0; m_data[k] = 16'h0;
            m_if_hold[k] = 16'h0; m_d_hold[k] = 16'h0; m_err[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < N; k++) begin
                lat = k + 1;
                if (rst_a[k]) begin
                    m_busy[k] = 1'b0; m_free[k] = cyc + 1; m_last_d[k] = 1'b0;
                    m_err[k] = 1'b0; m_if_hold[k] = 16'h0; m_d_hold[k] = 16'h0;
                    continue;
                end
                cur_k = k;
                e_re = 1'b0; e_we = 1'b0; e_ifd = 1'b0; e_dd = 1'b0;
                e_addr = 16'h0; e_wd = 16'h0;

                if (cyc >= m_free[k] && (if_req_a[k] || d_req_a[k])) begin
                    win_d = (if_req_a[k] && d_req_a[k]) ? !m_last_d[k] : d_req_a[k];
                    m_last_d[k] = win_d; m_own_d[k] = win_d; m_busy[k] = 1'b1;
                    m_issue[k] = cyc; m_done_cyc[k] = cyc + lat + 1; m_free[k] = cyc + lat + 2;
                    if (win_d) begin
                        e_addr = d_addr_a[k]; e_wd = d_wdata_a[k];
                        e_we = d_wr_a[k]; e_re = !d_wr_a[k];
                        m_own_addr[k] = d_addr_a[k]; m_own_wr[k] = d_wr_a[k];
                        m_own_wdata[k] = d_wdata_a[k];
                        if (d_wr_a[k]) begin
                            m_data[k] = 16'h0;
                            shadow[k][d_addr_a[k][9:0]] = d_wdata_a[k];
                        end else begin
                            m_data[k] = shadow[k][d_addr_a[k][9:0]];
                        end
                    end else begin
                        e_re = 1'b1; e_addr = if_addr_a[k];
                        m_own_addr[k] = if_addr_a[k];
                        m_data[k] = shadow[k][if_addr_a[k][9:0]];
                    end
                end

                check_eq("err", 32'(err_w[k]), 32'(m_err[k]));
                if (m_busy[k] && cyc > m_issue[k] && cyc <= m_issue[k] + lat) begin
                    if (m_own_d[k])
                        viol = !d_req_a[k] || d_addr_a[k] != m_own_addr[k] ||
                               d_wr_a[k] != m_own_wr[k] || d_wdata_a[k] != m_own_wdata[k];
                    else
                        viol = !if_req_a[k] || if_addr_a[k] != m_own_addr[k];
                    m_err[k] = m_err[k] | viol;
                end

                if (m_busy[k] && cyc == m_done_cyc[k]) begin
                    if (m_own_d[k]) begin e_dd = 1'b1; m_d_hold[k] = m_data[k]; end
                    else begin e_ifd = 1'b1; m_if_hold[k] = m_data[k]; end
                    m_busy[k] = 1'b0;
                end

                check_eq("mem_read_en",  32'(mem_re_w[k]),    32'(e_re));
                check_eq("mem_write_en", 32'(mem_we_w[k]),    32'(e_we));
                check_eq("mem_addr",     32'(mem_addr_w[k]),  32'(e_addr));
                check_eq("mem_wdata",    32'(mem_wdata_w[k]), 32'(e_wd));
                check_eq("if_done",      32'(if_done_w[k]),   32'(e_ifd));
                check_eq("d_done",       32'(d_done_w[k]),    32'(e_dd));
                check_eq("if_rdata",     32'(if_rdata_w[k]),  32'(m_if_hold[k]));
                check_eq("d_rdata",      32'(d_rdata_w[k]),   32'(m_d_hold[k]));
            end
        end
    end

    // Requester side: drops req the cycle after its done pulse.
    logic        saw_if, saw_d;
    logic [15:0] got_if_rdata, got_d_rdata;

    task automatic tick(input int k);
        @(negedge clk);
        saw_if = if_done_w[k];
        saw_d  = d_done_w[k];
        if (saw_if) got_if_rdata = if_rdata_w[k];
        if (saw_d)  got_d_rdata  = d_rdata_w[k];
        @(posedge clk); #1;
        if (saw_if) if_req_a[k] = 1'b0;
        if (saw_d)  d_req_a[k]  = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((if_req_a[k] || d_req_a[k]) && n < 40) begin
            tick(k);
            n++;
        end
        cur_k = k;
        check_eq("req_drain", 32'(if_req_a[k] | d_req_a[k]), 32'd0);
        if_req_a[k] = 1'b0;
        d_req_a[k]  = 1'b0;
    endtask

    task automatic do_reset(input int k);
        rst_a[k] = 1'b1;
        if_req_a[k] = 1'b0; d_req_a[k] = 1'b0; d_wr_a[k] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_a[k] = 1'b0;
    endtask

    task automatic run_inst(input int k);
        int      lat;
        int      ndone;
        logic [3:0] order;
        lat = k + 1;
        do_reset(k);

        got_if_rdata = 16'h0;
        if_req_a[k] = 1'b1; if_addr_a[k] = 16'h0010;
        wait_idle(k);
        check_eq("fetch_rdata", 32'(got_if_rdata), 32'h0000BEEF);

        got_d_rdata = 16'hFFFF;
        d_req_a[k] = 1'b1; d_wr_a[k] = 1'b1; d_addr_a[k] = 16'h0200; d_wdata_a[k] = 16'h1234;
        wait_idle(k);
        check_eq("write_rdata", 32'(got_d_rdata), 32'h0);
        got_d_rdata = 16'h0;
        d_req_a[k] = 1'b1; d_wr_a[k] = 1'b0;
        wait_idle(k);
        check_eq("readback", 32'(got_d_rdata), 32'h00001234);

        // Both held from reset: completion order must alternate D, IF, D, IF.
        do_reset(k);
        if_req_a[k] = 1'b1; if_addr_a[k] = 16'h0020;
        d_req_a[k] = 1'b1; d_wr_a[k] = 1'b0; d_addr_a[k] = 16'h0030;
        ndone = 0; order = 4'b0;
        for (int i = 0; i < 60 && ndone < 4; i++) begin
            tick(k);
            if (saw_if || saw_d) begin
                order = {order[2:0], saw_d};
                ndone++;
                if (ndone < 4) begin
                    if (saw_if) if_req_a[k] = 1'b1;
                    if (saw_d)  d_req_a[k]  = 1'b1;
                end
            end
        end
        cur_k = k;
        check_eq("grant_order", 32'(order), 32'b1010);
        if_req_a[k] = 1'b0;
        wait_idle(k);

        // Reset during WAIT aborts the access.
        d_req_a[k] = 1'b1; d_wr_a[k] = 1'b0; d_addr_a[k] = 16'h0040;
        @(posedge clk); #1;
        if (lat >= 2) begin
            @(posedge clk); #1;
        end
        rst_a[k] = 1'b1; d_req_a[k] = 1'b0;
        @(posedge clk); #1;
        rst_a[k] = 1'b0;
        @(negedge clk);
        cur_k = k;
        check_eq("rst_d_done",   32'(d_done_w[k]),   32'h0);
        check_eq("rst_mem_re",   32'(mem_re_w[k]),   32'h0);
        check_eq("rst_d_rdata",  32'(d_rdata_w[k]),  32'h0);
        check_eq("rst_if_rdata", 32'(if_rdata_w[k]), 32'h0);
        @(posedge clk); #1;
        got_if_rdata = 16'h0;
        if_req_a[k] = 1'b1; if_addr_a[k] = 16'h0011;
        wait_idle(k);
        check_eq("post_rst_fetch", 32'(got_if_rdata), 32'(init_word(16'h0011)));

        // Address changes while waiting: err sticks, access still completes.
        got_d_rdata = 16'h0;
        d_req_a[k] = 1'b1; d_wr_a[k] = 1'b0; d_addr_a[k] = 16'h0004;
        @(posedge clk); #1;
        d_addr_a[k] = 16'h0008;
        wait_idle(k);
        check_eq("viol_rdata", 32'(got_d_rdata), 32'(init_word(16'h0004)));
        for (int i = 0; i < 5; i++) tick(k);
        cur_k = k;
        check_eq("err_sticky", 32'(err_w[k]), 32'h1);
        do_reset(k);
        @(negedge clk);
        cur_k = k;
        check_eq("err_cleared", 32'(err_w[k]), 32'h0);
        @(posedge clk); #1;

        // Random traffic with well-behaved requesters.
        for (int i = 0; i < 300; i++) begin
            tick(k);
            if (!if_req_a[k] && $urandom_range(0, 3) == 0) begin
                if_req_a[k] = 1'b1;
                if_addr_a[k] = 16'($urandom_range(0, 63));
            end
            if (!d_req_a[k] && $urandom_range(0, 3) == 0) begin
                d_req_a[k] = 1'b1;
                d_wr_a[k] = 1'($urandom_range(0, 1));
                d_addr_a[k] = 16'($urandom_range(0, 63));
                d_wdata_a[k] = 16'($urandom);
            end
        end
        wait_idle(k);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_a[k] = 1'b1;
            if_req_a[k] = 1'b0; if_addr_a[k] = 16'h0;
            d_req_a[k] = 1'b0; d_wr_a[k] = 1'b0;
            d_addr_a[k] = 16'h0; d_wdata_a[k] = 16'h0;
        end
        saw_if = 1'b0; saw_d = 1'b0;
        got_if_rdata = 16'h0; got_d_rdata = 16'h0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) rst_a[k] = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) run_inst(k);
        repeat (4) begin
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
